// File: rtl/branch_resolve_queue_pkg.sv
// Shared types and constants for the branch resolve queue.
package brq_pkg;

    localparam int unsigned BRQ_PC_W        = 32;
    localparam int unsigned BRQ_INSTR_BYTES = 4;

    typedef struct packed {
        logic [BRQ_PC_W-1:0] pc;
        logic                pred;
    } brq_entry_t;

endpackage

// File: rtl/branch_resolve_queue_if.sv
// Fetch/execute/predictor-facing signal bundle of the branch resolve queue.
interface branch_resolve_queue_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PC_W  = 32
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             push_vld;
    logic [PC_W-1:0]  push_pc;
    logic             push_pred;
    logic             push_rdy;
    logic             ex_vld;
    logic             ex_taken;
    logic [PC_W-1:0]  ex_target;
    logic             flush_in;
    logic             upd_vld;
    logic [PC_W-1:0]  upd_pc;
    logic             upd_taken;
    logic             mispredict;
    logic [PC_W-1:0]  redirect_pc;
    logic [CNT_W-1:0] count;
    logic             err;

    modport master (
        output push_vld, push_pc, push_pred, ex_vld, ex_taken, ex_target, flush_in,
        input  push_rdy, upd_vld, upd_pc, upd_taken, mispredict, redirect_pc, count, err
    );

    modport slave (
        input  push_vld, push_pc, push_pred, ex_vld, ex_taken, ex_target, flush_in,
        output push_rdy, upd_vld, upd_pc, upd_taken, mispredict, redirect_pc, count, err
    );

endinterface

// File: rtl/branch_resolve_queue_fifo.sv
// Circular storage for in-flight predicted branches: pointers, occupancy, clear.
module brq_fifo
    import brq_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  brq_entry_t                 wr_data,
    output brq_entry_t                 rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    brq_entry_t       mem_q [DEPTH];
    brq_entry_t       mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    // Clear wins over push/pop; stored data is left stale since count gates it.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = PTR_W'(wr_ptr_q + PTR_W'(1));
            end
            if (pop) begin
                rd_ptr_d = PTR_W'(rd_ptr_q + PTR_W'(1));
            end
            case ({push, pop})
                2'b10:   count_d = CNT_W'(count_q + CNT_W'(1));
                2'b01:   count_d = CNT_W'(count_q - CNT_W'(1));
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);

endmodule

// File: rtl/branch_resolve_queue.sv
// Branch resolve queue: records fetch predictions, resolves them against execute,
// emits predictor training updates and mispredict redirects. BRQ_STATS_EN adds counters.
module branch_resolve_queue
    import brq_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PC_W  = BRQ_PC_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    branch_resolve_queue_if.slave  brq
`ifdef BRQ_STATS_EN
    ,
    output logic [31:0]            stat_branches,
    output logic [31:0]            stat_mispred
`endif
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    brq_entry_t       head;
    brq_entry_t       wr_entry;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;

    logic             pop_c;
    logic             mis_c;
    logic             push_c;
    logic             clear_c;
    logic             err_set_c;
    logic [PC_W-1:0]  head_pc_c;
    logic [PC_W-1:0]  redirect_c;

    logic             upd_vld_q,     upd_vld_d;
    logic [PC_W-1:0]  upd_pc_q,      upd_pc_d;
    logic             upd_taken_q,   upd_taken_d;
    logic             mispredict_q,  mispredict_d;
    logic [PC_W-1:0]  redirect_pc_q, redirect_pc_d;
    logic             err_q,         err_d;

    // Resolve decisions; flush suppresses every other event.
    always_comb begin
        pop_c      = brq.ex_vld & ~fifo_empty & ~brq.flush_in;
        mis_c      = pop_c & (brq.ex_taken != head.pred);
        push_c     = brq.push_vld & ~fifo_full & ~brq.flush_in & ~mis_c;
        clear_c    = brq.flush_in | mis_c;
        err_set_c  = brq.ex_vld & fifo_empty & ~brq.flush_in;
        head_pc_c  = PC_W'(head.pc);
        redirect_c = brq.ex_taken ? brq.ex_target
                                  : PC_W'(head_pc_c + PC_W'(BRQ_INSTR_BYTES));
    end

    assign wr_entry.pc   = BRQ_PC_W'(brq.push_pc);
    assign wr_entry.pred = brq.push_pred;

    brq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push_c),
        .pop     (pop_c),
        .clear   (clear_c),
        .wr_data (wr_entry),
        .rd_data (head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Output registers: pulses are rebuilt every cycle, data fields hold until next event.
    always_comb begin
        upd_vld_d     = pop_c;
        upd_pc_d      = upd_pc_q;
        upd_taken_d   = upd_taken_q;
        mispredict_d  = mis_c;
        redirect_pc_d = redirect_pc_q;
        err_d         = err_q | err_set_c;
        if (pop_c) begin
            upd_pc_d    = head_pc_c;
            upd_taken_d = brq.ex_taken;
        end
        if (mis_c) begin
            redirect_pc_d = redirect_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_vld_q     <= 1'b0;
            upd_pc_q      <= '0;
            upd_taken_q   <= 1'b0;
            mispredict_q  <= 1'b0;
            redirect_pc_q <= '0;
            err_q         <= 1'b0;
        end else begin
            upd_vld_q     <= upd_vld_d;
            upd_pc_q      <= upd_pc_d;
            upd_taken_q   <= upd_taken_d;
            mispredict_q  <= mispredict_d;
            redirect_pc_q <= redirect_pc_d;
            err_q         <= err_d;
        end
    end

    assign brq.push_rdy    = ~fifo_full;
    assign brq.count       = fifo_count;
    assign brq.upd_vld     = upd_vld_q;
    assign brq.upd_pc      = upd_pc_q;
    assign brq.upd_taken   = upd_taken_q;
    assign brq.mispredict  = mispredict_q;
    assign brq.redirect_pc = redirect_pc_q;
    assign brq.err         = err_q;

`ifdef BRQ_STATS_EN
    logic [31:0] stat_branches_q, stat_branches_d;
    logic [31:0] stat_mispred_q,  stat_mispred_d;

    // Wrapping event counters, untouched by flush.
    always_comb begin
        stat_branches_d = stat_branches_q;
        stat_mispred_d  = stat_mispred_q;
        if (pop_c) begin
            stat_branches_d = 32'(stat_branches_q + 32'd1);
        end
        if (mis_c) begin
            stat_mispred_d = 32'(stat_mispred_q + 32'd1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches_q <= '0;
            stat_mispred_q  <= '0;
        end else begin
            stat_branches_q <= stat_branches_d;
            stat_mispred_q  <= stat_mispred_d;
        end
    end

    assign stat_branches = stat_branches_q;
    assign stat_mispred  = stat_mispred_q;
`endif

endmodule
